// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, ALU opcodes and PSW flag positions.
package cpu_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_RA    = 5;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b1000;

  // PSW layout is {N, Z, C, V} from bit 3 down to bit 0.
  localparam int PSW_V = 0;
  localparam int PSW_C = 1;
  localparam int PSW_Z = 2;
  localparam int PSW_N = 3;

endpackage

// File: rtl/alu_ex_stage_alu.sv
// Combinational ALU: computes result and NZCV flags for one operation.
module ALU
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [3:0]       opcode,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       psw
);

  logic carry;
  logic overflow;

  // Subtraction is A + ~B + 1, so C is set when no borrow occurs.
  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (opcode)
      OP_ADD: begin
        {carry, result} = {1'b0, operandA} + {1'b0, operandB};
        overflow = (operandA[WIDTH-1] == operandB[WIDTH-1]) &&
                   (result[WIDTH-1] != operandA[WIDTH-1]);
      end
      OP_SUB: begin
        {carry, result} = {1'b0, operandA} + {1'b0, ~operandB} + {{WIDTH{1'b0}}, 1'b1};
        overflow = (operandA[WIDTH-1] != operandB[WIDTH-1]) &&
                   (result[WIDTH-1] != operandA[WIDTH-1]);
      end
      OP_AND:  result = operandA & operandB;
      OP_OR:   result = operandA | operandB;
      OP_XOR:  result = operandA ^ operandB;
      OP_NOT:  result = ~operandA;
      default: result = '0;
    endcase
    psw        = '0;
    psw[PSW_V] = overflow;
    psw[PSW_C] = carry;
    psw[PSW_Z] = (result == '0);
    psw[PSW_N] = result[WIDTH-1];
  end

endmodule

// File: rtl/alu_ex_stage.sv
// Execute stage: ID/EX register with operand forwarding, the ALU, an EX/MEM
// register toward memory/writeback, and the architectural PSW.
module alu_ex_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int RA    = DEFAULT_RA
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [RA-1:0]    in_rs1_addr,
  input  logic [RA-1:0]    in_rs2_addr,
  input  logic [WIDTH-1:0] in_rs1_data,
  input  logic [WIDTH-1:0] in_rs2_data,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_use_imm,
  input  logic [RA-1:0]    in_rd_addr,
  input  logic             in_rd_we,
  input  logic             in_psw_we,
  input  logic             flush,
  input  logic             wb_we,
  input  logic [RA-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RA-1:0]    out_rd_addr,
  output logic             out_rd_we,
  output logic [3:0]       psw
);

  logic             s1_valid;
  logic [3:0]       s1_opcode;
  logic [RA-1:0]    s1_rs1_addr;
  logic [RA-1:0]    s1_rs2_addr;
  logic [WIDTH-1:0] s1_rs1_data;
  logic [WIDTH-1:0] s1_rs2_data;
  logic [WIDTH-1:0] s1_imm;
  logic             s1_use_imm;
  logic [RA-1:0]    s1_rd_addr;
  logic             s1_rd_we;
  logic             s1_psw_we;
  logic             s2_valid;

  logic             s2_free;
  logic             s1_adv;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] fwd_rs2;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_psw;

  // The younger EX/MEM result wins over the writeback port; r0 never forwards.
  function automatic logic [WIDTH-1:0] fwd_operand(
    input logic [RA-1:0]    rs,
    input logic [WIDTH-1:0] reg_data,
    input logic             s2_hit_valid,
    input logic             s2_we,
    input logic [RA-1:0]    s2_rd,
    input logic [WIDTH-1:0] s2_res,
    input logic             wbp_we,
    input logic [RA-1:0]    wbp_addr,
    input logic [WIDTH-1:0] wbp_data
  );
    logic [WIDTH-1:0] value;
    value = reg_data;
    if (s2_hit_valid && s2_we && (s2_rd == rs) && (rs != '0)) begin
      value = s2_res;
    end else if (wbp_we && (wbp_addr == rs) && (rs != '0)) begin
      value = wbp_data;
    end
    return value;
  endfunction

  assign s2_free   = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_free && !flush;
  assign in_ready  = !s1_valid || s1_adv;
  assign out_valid = s2_valid;

  always_comb begin
    operand_a = fwd_operand(s1_rs1_addr, s1_rs1_data, s2_valid, out_rd_we, out_rd_addr,
                            out_result, wb_we, wb_addr, wb_data);
    fwd_rs2   = fwd_operand(s1_rs2_addr, s1_rs2_data, s2_valid, out_rd_we, out_rd_addr,
                            out_result, wb_we, wb_addr, wb_data);
    operand_b = s1_use_imm ? s1_imm : fwd_rs2;
  end

  ALU #(
    .WIDTH(WIDTH)
  ) u_alu (
    .operandA(operand_a),
    .operandB(operand_b),
    .opcode  (s1_opcode),
    .result  (alu_result),
    .psw     (alu_psw)
  );

  // A flushed cycle never loads S1, even though in_ready may still be high.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (in_valid && in_ready && !flush) begin
      s1_valid    <= 1'b1;
      s1_opcode   <= in_opcode;
      s1_rs1_addr <= in_rs1_addr;
      s1_rs2_addr <= in_rs2_addr;
      s1_rs1_data <= in_rs1_data;
      s1_rs2_data <= in_rs2_data;
      s1_imm      <= in_imm;
      s1_use_imm  <= in_use_imm;
      s1_rd_addr  <= in_rd_addr;
      s1_rd_we    <= in_rd_we;
      s1_psw_we   <= in_psw_we;
    end else if (s1_adv || flush) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid    <= 1'b0;
      out_result  <= '0;
      out_rd_addr <= '0;
      out_rd_we   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid    <= 1'b1;
      out_result  <= alu_result;
      out_rd_addr <= s1_rd_addr;
      out_rd_we   <= s1_rd_we;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psw <= '0;
    end else if (s1_adv && s1_psw_we) begin
      psw <= alu_psw;
    end
  end

endmodule
